cpu_insfetch: RTL

CPU_INSFETCH -- requirements
Module: cpu_insfetch

---
 rtl/cpu_pkg.sv | 18 +
 rtl/cpu_fetch_fifo.sv | 65 ++++++
 rtl/cpu_insfetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction fault codes and
// fetch-buffer sizing.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HALT    = 2'd2
  } fetch_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_ACCESS   = 2'b01;
  localparam logic [1:0] FAULT_MISALIGN = 2'b10;

  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] INSTR_NONE = 32'h0000_0000;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Small circular FIFO for fetched entries. Flush empties it in one cycle; a
// push in the flush cycle lands as the sole entry of the freshly emptied FIFO.
module cpu_fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               push_data_i,
  input  logic                           pop_i,
  input  logic                           flush_i,
  output logic [WIDTH-1:0]               head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q;
  logic [AW-1:0]    wr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    wr_idx;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A flush frees every slot, so a push in that cycle is always accepted.
  assign do_push = push_i && (flush_i || !full_o);
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign wr_idx  = flush_i ? '0 : wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rd_q    <= '0;
      wr_q    <= do_push ? next_ptr('0) : '0;
      count_q <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_q <= next_ptr(wr_q);
      if (do_pop)  rd_q <= next_ptr(rd_q);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= push_data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/cpu_insfetch.sv
// Instruction fetch stage: issues word fetches, buffers {instr, pc, fault}
// in a 2-entry FIFO for decode, and handles redirects and fetch faults.
module cpu_insfetch
  import cpu_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              mem_req,
  output logic [XLEN-1:0]                   mem_addr,
  input  logic                              mem_ready,
  input  logic [31:0]                       mem_rdata,
  input  logic                              mem_err,
  input  logic                              redirect_valid,
  input  logic [XLEN-1:0]                   redirect_pc,
  output logic                              instr_valid,
  output logic [31:0]                       instr,
  output logic [XLEN-1:0]                   instr_pc,
  output logic [1:0]                        instr_fault,
  input  logic                              instr_ready,
  output logic [1:0]                        dbg_state,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   dbg_count
);

  // Handshakes: a memory request completes on any cycle with mem_req=1 and
  // mem_ready=1 (data/err returned that cycle); once raised, mem_req and
  // mem_addr hold until completion. Decode consumes the head entry on any
  // cycle with instr_valid=1 and instr_ready=1, unless a redirect flushes it.

  localparam int EW = 32 + XLEN + 2;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] hold_q, hold_d;
  logic            run_q;

  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_flush;
  logic [EW-1:0]   fifo_wdata;
  logic [EW-1:0]   fifo_head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            target_misaligned;

  assign target_misaligned = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      hold_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    mem_req    = 1'b0;
    mem_addr   = pc_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    fifo_wdata = {INSTR_NONE, pc_q, FAULT_NONE};

    // run_q keeps the first cycle out of reset quiet so mem_req is a clean
    // registered-state function.
    case (state_q)
      ST_FETCH:   mem_req = run_q && !fifo_full;
      ST_DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = hold_q;
      end
      default: ;
    endcase

    if (redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = redirect_pc;
      if (target_misaligned) begin
        fifo_push  = 1'b1;
        fifo_wdata = {INSTR_NONE, redirect_pc, FAULT_MISALIGN};
      end
      // An in-flight request cannot be withdrawn; ride it out in DISCARD.
      if (mem_req && !mem_ready) begin
        state_d = ST_DISCARD;
        hold_d  = mem_addr;
      end else begin
        state_d = target_misaligned ? ST_HALT : ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (mem_req && mem_ready) begin
            fifo_push = 1'b1;
            if (mem_err) begin
              fifo_wdata = {INSTR_NONE, pc_q, FAULT_ACCESS};
              state_d    = ST_HALT;
            end else begin
              fifo_wdata = {mem_rdata, pc_q, FAULT_NONE};
              pc_d       = pc_q + XLEN'(4);
            end
          end
        end
        ST_DISCARD: begin
          if (mem_ready) state_d = (pc_q[1:0] != 2'b00) ? ST_HALT : ST_FETCH;
        end
        default: ;
      endcase
    end
  end

  assign fifo_pop = instr_valid && instr_ready && !redirect_valid;

  cpu_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .flush_i     (fifo_flush),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (dbg_count)
  );

  assign instr_valid                   = !fifo_empty;
  assign {instr, instr_pc, instr_fault} = fifo_head;
  assign dbg_state                     = state_q;

endmodule
